// File: rtl/mul_share_ctrl_pkg.sv
// mul_share_ctrl_pkg: state encodings and parameter defaults shared by the multiplier-sharing controller.
package mul_share_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;
    localparam int DEF_WIDTH         = 4;
    localparam int DEF_SETTLE_CYCLES = 7;
endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or above ptr, modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant
);
    // Scanning from the farthest offset down lets the nearest requester overwrite the rest.
    always_comb begin
        grant = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                grant = '0;
                grant[(int'(ptr) + k) % N_REQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one combinational multiplier, holding operands SETTLE_CYCLES
// clocks before capturing the product and returning it over valid/ready.
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [2*WIDTH-1:0]     resp_p,
    output logic                   busy,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [2*WIDTH-1:0]     mul_p
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_e             state_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      grant_q;
    logic [PW-1:0]      win;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;
    logic [2*WIDTH-1:0] resp_p_q;
    logic [N_REQ-1:0]   arb_grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_grant[i]) win = PW'(i);
    end

    // Ready is withheld during reset so no requester sees an accept that never happens.
    assign req_ready  = (rst_n && state_q == ST_IDLE) ? arb_grant : '0;
    assign resp_valid = (state_q == ST_RESP) ? (N_REQ'(1) << grant_q) : '0;
    assign busy       = state_q != ST_IDLE;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_p     = resp_p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            resp_p_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (|arb_grant) begin
                    mul_a_q <= req_a[int'(win)*WIDTH +: WIDTH];
                    mul_b_q <= req_b[int'(win)*WIDTH +: WIDTH];
                    grant_q <= win;
                    count_q <= CW'(SETTLE_CYCLES - 1);
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: if (count_q == '0) begin
                    resp_p_q <= mul_p;
                    state_q  <= ST_RESP;
                end else begin
                    count_q <= count_q - CW'(1);
                end
                ST_RESP: if (resp_ready[grant_q]) begin
                    rr_ptr_q <= (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed checks of arbitration, settle timing, response hold and reset abort.
module tb_mul_share_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [7:0]  resp_p;
    logic        busy;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    assign mul_p = mul_a * mul_b;

    mul_share_ctrl #(.N_REQ(4), .WIDTH(4), .SETTLE_CYCLES(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .busy       (busy),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int r, input int a, input int b);
        req_a[r*4 +: 4] = a[3:0];
        req_b[r*4 +: 4] = b[3:0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = '0;
        tick();
        tick();
    endtask

    task automatic wait_resp(input int r, output int n, output bit stable);
        logic [3:0] a0, b0;
        a0 = mul_a;
        b0 = mul_b;
        n = 1;
        stable = 1'b1;
        while (!resp_valid[r] && n < 50) begin
            tick();
            n++;
            if (mul_a !== a0 || mul_b !== b0) stable = 1'b0;
        end
    endtask

    task automatic release_resp(input int r);
        resp_ready = 4'b1 << r;
        tick();
        resp_ready = '0;
    endtask

    initial begin
        int  n, last;
        bit  st, ok;
        int  ord [5] = '{0, 1, 2, 3, 0};
        req_a = '0;
        req_b = '0;
        do_reset();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_resp_p", resp_p, 0);
        rst_n = 1'b1;

        set_op(0, 15, 0);
        req_valid = 4'b0001;
        #1 chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("t1_busy", busy, 1);
        chk("t1_mul_a", mul_a, 15);
        wait_resp(0, n, st);
        chk("t1_latency", n, 8);
        chk("t1_resp_valid", resp_valid, 4'b0001);
        chk("t1_resp_p", resp_p, 0);
        release_resp(0);
        chk("t1_idle", busy, 0);

        set_op(1, 15, 15);
        req_valid = 4'b0010;
        #1 chk("t2_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_resp(1, n, st);
        chk("t2_latency", n, 8);
        chk("t2_stable", st, 1);
        chk("t2_resp_p", resp_p, 8'hE1);
        release_resp(1);
        chk("t2_hold_a", mul_a, 15);

        do_reset();
        rst_n = 1'b1;
        set_op(0, 6, 7);
        set_op(2, 3, 5);
        req_valid = 4'b0101;
        #1 chk("t3_ready0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0100;
        chk("t3_settle_ready", req_ready, 0);
        wait_resp(0, n, st);
        chk("t3_resp0", resp_p, 42);
        release_resp(0);
        chk("t3_ready2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_resp(2, n, st);
        chk("t3_resp_valid2", resp_valid, 4'b0100);
        chk("t3_resp2", resp_p, 15);
        release_resp(2);

        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, i + 1, i + 2);
        req_valid = 4'hF;
        resp_ready = 4'hF;
        #1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_ready == 0 && n < 50) begin
                tick();
                n++;
            end
            chk($sformatf("t4_order%0d", g), req_ready, 4'b1 << ord[g]);
            if (g > 0) chk($sformatf("t4_gap%0d", g), cyc - last, 9);
            last = cyc;
            tick();
        end
        req_valid = '0;
        resp_ready = '0;

        do_reset();
        rst_n = 1'b1;
        set_op(1, 9, 13);
        set_op(0, 2, 2);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0001;
        wait_resp(1, n, st);
        chk("t5_resp_p", resp_p, 117);
        resp_ready = 4'b1101;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (resp_valid !== 4'b0010 || resp_p !== 8'd117 || busy !== 1'b1 || req_ready !== 4'b0) ok = 1'b0;
        end
        chk("t5_held", ok, 1);
        release_resp(1);
        chk("t5_next_ready", req_ready, 4'b0001);

        do_reset();
        rst_n = 1'b1;
        set_op(0, 4, 4);
        set_op(3, 11, 12);
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b1000;
        tick();
        tick();
        chk("t6_mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_mul_a", mul_a, 0);
        chk("t6_mul_b", mul_b, 0);
        chk("t6_resp_p", resp_p, 0);
        chk("t6_ready_in_rst", req_ready, 0);
        rst_n = 1'b1;
        #1 chk("t6_ready3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        wait_resp(3, n, st);
        chk("t6_resp_valid3", resp_valid, 4'b1000);
        chk("t6_resp_p3", resp_p, 132);
        release_resp(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
